// File: rtl/periph_bus_arbiter_if.sv
// periph_bus_arbiter_if: one data port (request fields out, grant/response back).
// The master modport drives the request; the slave modport answers it.
interface periph_bus_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/periph_bus_arbiter.sv
// periph_bus_arbiter: two-master round-robin arbiter in front of the peripheral (UART) data port.
// Optional macro PERIPH_ARB_TIMEOUT_EN aborts a stalled transaction and returns ERR_RDATA.
module periph_bus_arbiter #(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 10,
  parameter int unsigned           TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA      = DATA_WIDTH'(32'hDEADBEEF)
) (
  input  logic                        clk,
  input  logic                        reset,
  periph_bus_arbiter_if.slave         m0_data,
  periph_bus_arbiter_if.slave         m1_data,
  periph_bus_arbiter_if.master        slave_data,
  output logic                        arb_owner_o,
  output logic                        arb_busy_o,
  output logic                        timeout_o
);
  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t                state_q;
  state_t                state_d;
  req_t                  lat_q;
  req_t                  m0_fields;
  req_t                  m1_fields;
  logic                  owner_q;
  logic                  rr_last_q;
  logic                  any_req;
  logic                  winner;
  logic                  complete;
  logic                  abort;
  logic                  slave_req;
  logic                  fwd_gnt;
  logic                  fwd_rvalid;
  logic [DATA_WIDTH-1:0] fwd_rdata;

  // Arbitration: a lone requester wins; on a tie the master that did not win last time wins.
  assign any_req   = m0_data.req | m1_data.req;
  assign winner    = (m0_data.req & m1_data.req) ? ~rr_last_q : m1_data.req;
  assign m0_fields = '{addr: m0_data.addr, we: m0_data.we, be: m0_data.be, wdata: m0_data.wdata};
  assign m1_fields = '{addr: m1_data.addr, we: m1_data.we, be: m1_data.be, wdata: m1_data.wdata};

  assign complete = ((state_q == REQ) & slave_data.gnt & slave_data.rvalid)
                  | ((state_q == RESP) & slave_data.rvalid);

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic [CNT_WIDTH-1:0] tmo_cnt_q;

  // Age of the open transaction; a completion in the expiry cycle takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (any_req) tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign abort = (state_q != IDLE) & ~complete
               & (tmo_cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^{ERR_RDATA, CNT_WIDTH'(TIMEOUT_CYCLES)};
  assign abort          = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (any_req) state_d = REQ;
      REQ: begin
        if (slave_data.gnt && slave_data.rvalid) state_d = IDLE;
        else if (slave_data.gnt)                 state_d = RESP;
      end
      RESP:    if (slave_data.rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // FSM outputs: grant/response are forwarded in the same cycle the peripheral produces them.
  always_comb begin
    slave_req  = 1'b0;
    fwd_gnt    = 1'b0;
    fwd_rvalid = 1'b0;
    fwd_rdata  = '0;
    case (state_q)
      REQ: begin
        slave_req  = 1'b1;
        fwd_gnt    = slave_data.gnt | abort;
        fwd_rvalid = (slave_data.gnt & slave_data.rvalid) | abort;
      end
      RESP:    fwd_rvalid = slave_data.rvalid | abort;
      default: ;
    endcase
    if (reset) begin
      fwd_gnt    = 1'b0;
      fwd_rvalid = 1'b0;
    end
    if (fwd_rvalid) fwd_rdata = abort ? ERR_RDATA : slave_data.rdata;
  end

  // Winner's request fields and ownership are captured when leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      lat_q     <= '0;
    end else if ((state_q == IDLE) && any_req) begin
      owner_q   <= winner;
      rr_last_q <= winner;
      lat_q     <= winner ? m1_fields : m0_fields;
    end
  end

  assign m0_data.gnt    = fwd_gnt & ~owner_q;
  assign m0_data.rvalid = fwd_rvalid & ~owner_q;
  assign m0_data.rdata  = owner_q ? '0 : fwd_rdata;
  assign m1_data.gnt    = fwd_gnt & owner_q;
  assign m1_data.rvalid = fwd_rvalid & owner_q;
  assign m1_data.rdata  = owner_q ? fwd_rdata : '0;

  assign slave_data.req   = slave_req;
  assign slave_data.addr  = lat_q.addr;
  assign slave_data.we    = lat_q.we;
  assign slave_data.be    = lat_q.be;
  assign slave_data.wdata = lat_q.wdata;

  assign arb_owner_o = owner_q;
  assign arb_busy_o  = (state_q != IDLE);
  assign timeout_o   = abort & ~reset;
endmodule

// File: tb/tb_periph_bus_arbiter.sv
// tb_periph_bus_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
// Build with +define+PERIPH_ARB_TIMEOUT_EN to exercise the abort path.
module tb_periph_bus_arbiter;
  localparam int unsigned TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  bit   clk = 1'b0;
  logic reset;
  logic arb_owner, arb_busy, timeout;

  periph_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) m0_if ();
  periph_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) m1_if ();
  periph_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) s_if ();

  periph_bus_arbiter #(
    .DATA_WIDTH(32), .ADDR_WIDTH(10), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_data(m0_if), .m1_data(m1_if), .slave_data(s_if),
    .arb_owner_o(arb_owner), .arb_busy_o(arb_busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: at most one open transaction and the identity of the last winner.
  logic        mo_open, mo_granted, mo_own, mo_last;
  int unsigned mo_age;
  logic [9:0]  mo_addr;
  logic        mo_we;
  logic [3:0]  mo_be;
  logic [31:0] mo_wdata;
  logic        e_g, e_v, e_to;
  logic [31:0] e_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_eval();
    e_g = 1'b0; e_v = 1'b0; e_to = 1'b0; e_rd = 32'h0;
    if (mo_open && !mo_granted) begin
      e_g = s_if.gnt;
      e_v = s_if.gnt && s_if.rvalid;
    end else if (mo_open) begin
      e_v = s_if.rvalid;
    end
`ifdef PERIPH_ARB_TIMEOUT_EN
    if (mo_open && !e_v && mo_age == TMO - 1) begin
      e_g  = e_g | !mo_granted;
      e_v  = 1'b1;
      e_to = 1'b1;
    end
`endif
    if (e_v) e_rd = e_to ? ERR : s_if.rdata;
    if (reset) begin
      e_g = 1'b0; e_v = 1'b0; e_to = 1'b0; e_rd = 32'h0;
    end
  endtask

  task automatic model_tick();
    logic w;
    if (reset) begin
      mo_open = 1'b0; mo_granted = 1'b0; mo_own = 1'b0; mo_last = 1'b1; mo_age = 0;
      mo_addr = '0; mo_we = 1'b0; mo_be = '0; mo_wdata = '0;
    end else if (mo_open) begin
      if (e_v) mo_open = 1'b0;
      else begin
        if (e_g) mo_granted = 1'b1;
        mo_age++;
      end
    end else if (m0_if.req || m1_if.req) begin
      w = (m0_if.req && m1_if.req) ? !mo_last : m1_if.req;
      mo_open = 1'b1; mo_granted = 1'b0; mo_age = 0; mo_own = w; mo_last = w;
      mo_addr  = w ? m1_if.addr  : m0_if.addr;
      mo_we    = w ? m1_if.we    : m0_if.we;
      mo_be    = w ? m1_if.be    : m0_if.be;
      mo_wdata = w ? m1_if.wdata : m0_if.wdata;
    end
  endtask

  task automatic compare_all();
    check("busy",      32'(arb_busy),     32'(mo_open));
    check("owner",     32'(arb_owner),    32'(mo_own));
    check("timeout",   32'(timeout),      32'(e_to));
    check("s_req",     32'(s_if.req),     32'(mo_open && !mo_granted));
    check("s_addr",    32'(s_if.addr),    32'(mo_addr));
    check("s_we",      32'(s_if.we),      32'(mo_we));
    check("s_be",      32'(s_if.be),      32'(mo_be));
    check("s_wdata",   s_if.wdata,        mo_wdata);
    check("m0_gnt",    32'(m0_if.gnt),    32'(e_g && !mo_own));
    check("m0_rvalid", 32'(m0_if.rvalid), 32'(e_v && !mo_own));
    check("m0_rdata",  m0_if.rdata,       mo_own ? 32'h0 : e_rd);
    check("m1_gnt",    32'(m1_if.gnt),    32'(e_g && mo_own));
    check("m1_rvalid", 32'(m1_if.rvalid), 32'(e_v && mo_own));
    check("m1_rdata",  m1_if.rdata,       mo_own ? e_rd : 32'h0);
  endtask

  task automatic half();
    @(negedge clk);
    model_eval();
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.req = 1'b0; m0_if.addr = '0; m0_if.we = 1'b0; m0_if.be = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.addr = '0; m1_if.we = 1'b0; m1_if.be = '0; m1_if.wdata = '0;
    s_if.gnt = 1'b0; s_if.rvalid = 1'b0; s_if.rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    @(posedge clk);
    model_tick();
    #1;
    reset = 1'b0;
  endtask

  task automatic rand_req0();
    m0_if.req = 1'b1; m0_if.addr = 10'($urandom); m0_if.we = 1'($urandom);
    m0_if.be = 4'($urandom); m0_if.wdata = $urandom;
  endtask

  task automatic rand_req1();
    m1_if.req = 1'b1; m1_if.addr = 10'($urandom); m1_if.we = 1'($urandom);
    m1_if.be = 4'($urandom); m1_if.wdata = $urandom;
  endtask

  initial begin
    logic g0, g1;
    do_reset();

    // m0 write of 0x41 to 0x000, peripheral answers one cycle after seeing the request.
    m0_if.req = 1'b1; m0_if.we = 1'b1; m0_if.be = 4'hF; m0_if.wdata = 32'h41;
    half(); check("t1_sreq_c0", 32'(s_if.req), 32'd0); tick();
    half(); check("t1_sreq_c1", 32'(s_if.req), 32'd1); check("t1_wdata", s_if.wdata, 32'h41); tick();
    s_if.gnt = 1'b1; s_if.rvalid = 1'b1;
    half();
    check("t1_m0_gnt", 32'(m0_if.gnt), 32'd1); check("t1_m0_rvalid", 32'(m0_if.rvalid), 32'd1);
    check("t1_m1_gnt", 32'(m1_if.gnt), 32'd0); check("t1_m1_rvalid", 32'(m1_if.rvalid), 32'd0);
    tick();
    m0_if.req = 1'b0; s_if.gnt = 1'b0; s_if.rvalid = 1'b0;
    half(); check("t1_idle", 32'(arb_busy), 32'd0); tick();

    // Both masters held from reset with an always-ready peripheral: strict alternation.
    do_reset();
    m0_if.req = 1'b1; m1_if.req = 1'b1; s_if.gnt = 1'b1; s_if.rvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      half();
      if (c % 2 == 1) begin
        check("alt_m0", 32'(m0_if.gnt), 32'((c / 2) % 2 == 0));
        check("alt_m1", 32'(m1_if.gnt), 32'((c / 2) % 2 == 1));
      end
      tick();
    end

    // m1 read of 0x004 returns 0x00123456 only on m1.
    do_reset();
    m1_if.req = 1'b1; m1_if.addr = 10'h004;
    half(); tick();
    half(); tick();
    s_if.gnt = 1'b1; s_if.rvalid = 1'b1; s_if.rdata = 32'h00123456;
    half();
    check("t3_m1_rdata", m1_if.rdata, 32'h00123456); check("t3_m1_rvalid", 32'(m1_if.rvalid), 32'd1);
    check("t3_m0_rdata", m0_if.rdata, 32'h0);
    tick();
    m1_if.req = 1'b0; s_if.gnt = 1'b0; s_if.rvalid = 1'b0;
    half(); tick();

    // Split transaction: gnt in cycle 2, rvalid in cycle 4, then a stray rvalid in IDLE.
    do_reset();
    m0_if.req = 1'b1; m0_if.addr = 10'h008;
    half(); tick();
    half(); tick();
    s_if.gnt = 1'b1;
    half(); check("t4_gnt", 32'(m0_if.gnt), 32'd1); tick();
    m0_if.req = 1'b0; s_if.gnt = 1'b0;
    half();
    check("t4_resp_busy", 32'(arb_busy), 32'd1); check("t4_resp_sreq", 32'(s_if.req), 32'd0);
    check("t4_no_early_rv", 32'(m0_if.rvalid), 32'd0);
    tick();
    s_if.rvalid = 1'b1; s_if.rdata = 32'hCAFE0001;
    half(); check("t4_rv", 32'(m0_if.rvalid), 32'd1); check("t4_rdata", m0_if.rdata, 32'hCAFE0001); tick();
    half(); check("t4_idle_ignore", 32'(m0_if.rvalid), 32'd0); check("t4_idle", 32'(arb_busy), 32'd0); tick();

    // Reset while m1 owns a pending request; afterwards m0 wins the tie again.
    do_reset();
    m0_if.req = 1'b1; s_if.gnt = 1'b1; s_if.rvalid = 1'b1;
    half(); tick();
    half(); tick();
    m1_if.req = 1'b1;
    half(); tick();
    reset = 1'b1;
    half(); check("t5_rst_nognt", 32'(m1_if.gnt), 32'd0); check("t5_rst_norv", 32'(m1_if.rvalid), 32'd0); tick();
    reset = 1'b0; s_if.gnt = 1'b0; s_if.rvalid = 1'b0;
    half(); check("t5_sreq_drop", 32'(s_if.req), 32'd0); check("t5_busy_drop", 32'(arb_busy), 32'd0); tick();
    half(); check("t5_m0_first", 32'(arb_owner), 32'd0); check("t5_sreq", 32'(s_if.req), 32'd1); tick();

    // Silent peripheral.
    do_reset();
    m0_if.req = 1'b1;
`ifdef PERIPH_ARB_TIMEOUT_EN
    for (int c = 0; c < 10; c++) begin
      half();
      if (c == 8) begin
        check("tmo_gnt", 32'(m0_if.gnt), 32'd1); check("tmo_rv", 32'(m0_if.rvalid), 32'd1);
        check("tmo_rdata", m0_if.rdata, ERR); check("tmo_pulse", 32'(timeout), 32'd1);
      end else begin
        check("tmo_quiet", 32'(timeout), 32'd0);
      end
      tick();
      if (c == 8) m0_if.req = 1'b0;
    end
`else
    for (int c = 0; c < 12; c++) begin
      half(); check("no_tmo", 32'(timeout), 32'd0); tick();
    end
    half(); check("no_tmo_wait", 32'(arb_busy), 32'd1); tick();
`endif

    // Random traffic with occasional resets, early request drops and stray slave strobes.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!m0_if.req && $urandom_range(0, 2) == 0) rand_req0();
      if (!m1_if.req && $urandom_range(0, 2) == 0) rand_req1();
      s_if.gnt    = ($urandom_range(0, 3) == 0);
      s_if.rvalid = ($urandom_range(0, 2) == 0);
      s_if.rdata  = $urandom;
      reset       = ($urandom_range(0, 149) == 0);
      half();
      g0 = e_g && !mo_own;
      g1 = e_g && mo_own;
      tick();
      if (g0 || $urandom_range(0, 49) == 0) m0_if.req = 1'b0;
      if (g1 || $urandom_range(0, 49) == 0) m1_if.req = 1'b0;
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
